// File: rtl/ddr3_read_return.sv
// Host-side read-return stage: turns host read requests into return-FIFO pops,
// registers the returned words, tracks bursts and checks address continuity.
module ddr3_read_return #(
  parameter int BL     = 8,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              resetbar,
  input  logic              read,
  input  logic [41:0]       fifo_data,
  input  logic              fifo_notempty,
  output logic              fifo_get,
  output logic [15:0]       dout,
  output logic [25:0]       raddr,
  output logic              validout,
  output logic              burst_done,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              addr_err
);
  localparam int                IDX_W    = $clog2(BL);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BL - 1);

  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              addr_err_q, addr_err_d;
  logic              get_d1_q;
  logic              validout_q;
  logic              burst_done_q, burst_done_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       dout_q, dout_d;
  logic [25:0]       raddr_q, raddr_d;

  logic              drop;
  logic [25:0]       addr_in;
  logic [25:0]       addr_exp;
  logic              addr_bad;

  assign fifo_get = resetbar & (pending_q != '0) & fifo_notempty;
  // A pop in the same cycle frees a slot, so a read at saturation is only
  // dropped when nothing is popped.
  assign drop     = read & ~fifo_get & (pending_q == PEND_MAX);
  assign addr_in  = fifo_data[41:16];
  assign addr_exp = raddr_q + 26'd1;
  assign addr_bad = get_d1_q & (idx_q != '0) & (addr_in != addr_exp);

  always_comb begin
    pending_d    = pending_q;
    overflow_d   = overflow_q | drop;
    addr_err_d   = addr_err_q | addr_bad;
    idx_d        = idx_q;
    dout_d       = dout_q;
    raddr_d      = raddr_q;
    burst_done_d = 1'b0;

    if (read && !fifo_get && !drop) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!read && fifo_get) begin
      pending_d = pending_q - PEND_W'(1);
    end

    if (get_d1_q) begin
      dout_d       = fifo_data[15:0];
      raddr_d      = addr_in;
      idx_d        = idx_q + IDX_W'(1);
      burst_done_d = (idx_q == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetbar) begin
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      addr_err_q   <= 1'b0;
      get_d1_q     <= 1'b0;
      validout_q   <= 1'b0;
      burst_done_q <= 1'b0;
      idx_q        <= '0;
      dout_q       <= '0;
      raddr_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      addr_err_q   <= addr_err_d;
      get_d1_q     <= fifo_get;
      validout_q   <= get_d1_q;
      burst_done_q <= burst_done_d;
      idx_q        <= idx_d;
      dout_q       <= dout_d;
      raddr_q      <= raddr_d;
    end
  end

  assign dout       = dout_q;
  assign raddr      = raddr_q;
  assign validout   = validout_q;
  assign burst_done = burst_done_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ddr3_read_return.sv
// Bench for ddr3_read_return: a registered-read FIFO model feeds the DUT and a
// transaction-level reference model predicts every output cycle by cycle.
module tb_ddr3_read_return;
  localparam int BL       = 8;
  localparam int PEND_W   = 3;
  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic              clk = 1'b0;
  logic              resetbar = 1'b0;
  logic              read = 1'b0;
  logic [41:0]       fifo_data = '0;
  logic              fifo_notempty;
  logic              fifo_get;
  logic [15:0]       dout;
  logic [25:0]       raddr;
  logic              validout;
  logic              burst_done;
  logic [PEND_W-1:0] pending;
  logic              overflow;
  logic              addr_err;

  ddr3_read_return #(.BL(BL), .PEND_W(PEND_W)) dut (
    .clk(clk), .resetbar(resetbar), .read(read),
    .fifo_data(fifo_data), .fifo_notempty(fifo_notempty), .fifo_get(fifo_get),
    .dout(dout), .raddr(raddr), .validout(validout), .burst_done(burst_done),
    .pending(pending), .overflow(overflow), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Return FIFO: everything ever loaded, plus a read pointer advanced by pops.
  logic [41:0] load_q[$];
  int          n_loaded = 0;
  int          rd_ptr = 0;

  assign fifo_notempty = (n_loaded > rd_ptr);

  always @(posedge clk) begin
    if (fifo_get && rd_ptr < n_loaded) begin
      fifo_data <= load_q[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [25:0] a, input logic [15:0] d);
    load_q.push_back({a, d});
    n_loaded++;
  endtask

  // Reference model: request count, entries consumed, words in flight with
  // their delivery cycle, and per-reset word count for burst position.
  typedef struct {
    int          due;
    logic [41:0] e;
  } flight_t;

  flight_t     m_fly[$];
  int          m_pend = 0;
  int          m_rd = 0;
  int          m_cyc = 0;
  int          m_nword = 0;
  bit          m_ovf = 0, m_aerr = 0, m_valid = 0, m_bdone = 0;
  logic [15:0] m_dout = '0;
  logic [25:0] m_raddr = '0;

  logic        seen_get;
  logic [49:0] exp_vec;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [49:0] dut_vec();
    return {seen_get, validout, burst_done, overflow, addr_err, pending, dout, raddr};
  endfunction

  task automatic tick(input bit rd);
    bit          exp_get;
    flight_t     f;
    logic [25:0] a;
    read = rd;
    #1;
    seen_get = fifo_get;
    exp_get  = resetbar && (m_pend > 0) && (n_loaded > m_rd);
    @(posedge clk);
    m_cyc++;
    m_valid = 0;
    m_bdone = 0;
    if (!resetbar) begin
      m_fly.delete();
      m_pend = 0; m_nword = 0; m_ovf = 0; m_aerr = 0;
      m_dout = '0; m_raddr = '0;
    end else begin
      if (m_fly.size() > 0 && m_fly[0].due == m_cyc) begin
        f = m_fly.pop_front();
        a = f.e[41:16];
        if ((m_nword % BL) != 0 && a != 26'(m_raddr + 26'd1)) m_aerr = 1;
        m_bdone = ((m_nword % BL) == BL - 1);
        m_nword++;
        m_dout  = f.e[15:0];
        m_raddr = a;
        m_valid = 1;
      end
      if (exp_get) begin
        f.due = m_cyc + 1;
        f.e   = load_q[m_rd];
        m_fly.push_back(f);
        m_rd++;
      end
      if (rd && !exp_get) begin
        if (m_pend == PEND_MAX) m_ovf = 1;
        else m_pend++;
      end else if (!rd && exp_get) begin
        m_pend--;
      end
    end
    exp_vec = {exp_get, m_valid, m_bdone, m_ovf, m_aerr, PEND_W'(m_pend), m_dout, m_raddr};
    @(negedge clk);
  endtask

  task automatic apply_reset();
    resetbar = 1'b0;
    tick(0);
    tick(0);
    resetbar = 1'b1;
  endtask

  task automatic test_reset();
    push(26'h0000100, 16'hBEEF);
    resetbar = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      n_tests++;
      if (seen_get !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_get: fifo_get %b expected 0", seen_get);
      end
    end
    resetbar = 1'b1;
    tick(0);
    n_tests++;
    if ({validout, burst_done, overflow, addr_err, pending, dout, raddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0",
               {validout, burst_done, overflow, addr_err, pending, dout, raddr});
    end
  endtask

  task automatic test_single_read();
    for (int i = 0; i < 5; i++) begin
      tick(i == 0);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      if (i == 1) begin
        n_tests++;
        if (seen_get !== 1'b1) begin
          n_fail++;
          $display("FAIL single_get_latency: fifo_get %b expected 1", seen_get);
        end
      end
      if (i == 2) begin
        n_tests++;
        if ({validout, dout, raddr} !== {1'b1, 16'hBEEF, 26'h0000100}) begin
          n_fail++;
          $display("FAIL single_word: got %h expected %h",
                   {validout, dout, raddr}, {1'b1, 16'hBEEF, 26'h0000100});
        end
      end
    end
  endtask

  task automatic test_burst();
    int nv = 0, nb = 0, bd_at = -1;
    apply_reset();
    for (int i = 0; i < 8; i++) push(26'(26'h3FFFFFC + i), 16'(i));
    for (int i = 0; i < 12; i++) begin
      tick(i < 8);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL burst cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      if (validout) nv++;
      if (burst_done) begin
        nb++;
        bd_at = nv;
      end
    end
    n_tests++;
    if (nv != 8 || nb != 1 || bd_at != 8 || addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_summary: words %0d done %0d at %0d err %b expected 8 1 8 0",
               nv, nb, bd_at, addr_err);
    end
  endtask

  task automatic test_empty_stall();
    int ng = 0, nv = 0;
    logic [2:0] first_gets = '0;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      tick(i % 2 == 0);
      if (seen_get) ng++;
    end
    n_tests++;
    if (pending !== PEND_W'(3) || ng != 0) begin
      n_fail++;
      $display("FAIL stall_pending: pending %0d gets %0d expected 3 0", pending, ng);
    end
    for (int i = 0; i < 3; i++) push(26'(26'h200 + i), 16'(16'hA000 + i));
    for (int i = 0; i < 6; i++) begin
      tick(0);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL stall cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      if (i < 3) first_gets[i] = seen_get;
      if (validout) nv++;
    end
    n_tests++;
    if (first_gets !== 3'b111 || nv != 3 || pending !== '0) begin
      n_fail++;
      $display("FAIL stall_drain: gets %b words %0d pending %0d expected 111 3 0",
               first_gets, nv, pending);
    end
  endtask

  task automatic test_addr_error();
    int nv = 0, err_at = -1;
    apply_reset();
    push(26'h0000100, 16'h1);
    for (int i = 1; i < 8; i++) push(26'(26'h0000104 + i), 16'(16'h1 + i));
    for (int i = 0; i < 8; i++) push(26'(26'h0000300 + i), 16'(16'h30 + i));
    for (int i = 0; i < 20; i++) begin
      tick(i < 16);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL addr_err cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      if (validout) nv++;
      if (addr_err === 1'b1 && err_at < 0) err_at = nv;
    end
    n_tests++;
    if (err_at != 2 || addr_err !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_err_sticky: first at word %0d flag %b expected 2 1", err_at, addr_err);
    end
    apply_reset();
    n_tests++;
    if (addr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_err_clear: flag %b expected 0", addr_err);
    end
  endtask

  task automatic test_overflow();
    int nv = 0;
    apply_reset();
    for (int i = 0; i < 16; i++) tick(i % 2 == 0);
    n_tests++;
    if (pending !== PEND_W'(PEND_MAX) || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sat: pending %0d ovf %b expected %0d 1", pending, overflow, PEND_MAX);
    end
    for (int i = 0; i < 9; i++) push(26'(26'h400 + i), 16'(16'h4000 + i));
    for (int i = 0; i < 14; i++) begin
      tick(0);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL overflow cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
      if (validout) nv++;
    end
    n_tests++;
    if (nv != PEND_MAX || pending !== '0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_drain: words %0d pending %0d ovf %b expected %0d 0 1",
               nv, pending, overflow, PEND_MAX);
    end
  endtask

  task automatic test_random();
    logic [25:0] next_a = 26'h3FFFFF0;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        if ($urandom_range(0, 9) == 0) next_a = 26'($urandom);
        push(next_a, 16'($urandom));
        next_a = next_a + 26'd1;
      end
      resetbar = ($urandom_range(0, 149) != 0);
      tick($urandom_range(0, 99) < 45);
      n_tests++;
      if (dut_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", m_cyc, dut_vec(), exp_vec);
      end
    end
    resetbar = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_burst();
    test_empty_stall();
    test_addr_error();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_read_return.md
# ddr3_read_return

Host-side read-return stage that drains the controller's return FIFO and delivers read words to the host. It sits directly downstream of the DDR3 controller's 42-bit return FIFO, whose entries are {address[25:0], data[15:0]}. It turns host `read` request pulses into FIFO pops and presents registered `dout`/`raddr` with a one-cycle `validout` strobe. It also tracks burst boundaries and checks that addresses within each burst are contiguous.

## Interface
Parameters:
- BL, 8, words per read burst; power of 2, 2..8
- PEND_W, 3, width of outstanding-request counter; max outstanding = 2^PEND_W - 1

Ports:
- clk  in  1  single clock for all logic
- resetbar  in  1  synchronous, active-low reset (sampled on rising clk)
- read  in  1  host request: one word per cycle it is high
- fifo_data  in  42  return FIFO data_out, {addr[41:16], data[15:0]}
- fifo_notempty  in  1  return FIFO empty_bar
- fifo_get  out  1  return FIFO re (pop)
- dout  out  16  returned data word
- raddr  out  26  address of `dout`
- validout  out  1  one-cycle strobe: dout/raddr valid this cycle
- burst_done  out  1  coincident with validout on the last word of a BL-word burst
- pending  out  PEND_W  accepted requests not yet popped
- overflow  out  1  sticky: a read was dropped because pending was saturated
- addr_err  out  1  sticky: a non-contiguous address was seen inside a burst

## Operation
- Return FIFO: registered read. data_out is valid after the edge that ends a cycle with re=1. empty_bar updates on that same edge.
- Request counter `pending`, updated each edge:
  - +1 on read
  - -1 on fifo_get
  - unchanged when both occur
  - read while pending = max and no fifo_get: request dropped, overflow set to 1
- fifo_get is combinational: resetbar & (pending != 0) & fifo_notempty.
  - Never asserted when the FIFO is empty, so no underflow.
  - Sustains one pop per cycle.
- Pipeline register get_d1 <= fifo_get.
  - When get_d1 = 1: dout <= fifo_data[15:0], raddr <= fifo_data[41:16], validout <= 1.
  - Otherwise validout <= 0; dout and raddr hold their last value.
- Burst tracking, log2(BL)-bit index `idx` advanced on each delivered word:
  - idx = 0: first word of a burst; store raddr, no check.
  - idx != 0: word must equal previous raddr + 1, computed modulo 2^26 (wrap from 0x3FFFFFF to 0 is legal). Mismatch sets addr_err.
  - idx = BL-1: burst_done = 1 with that validout; idx wraps to 0.
- Sticky flags clear only on reset.

## Timing
- Reset, with resetbar low at an edge, forces:
  - pending = 0, idx = 0, get_d1 = 0
  - validout = 0, burst_done = 0, overflow = 0, addr_err = 0
  - dout = 0, raddr = 0
  - fifo_get = 0 for as long as resetbar is low
- Reset mid-operation: in-flight pops and pending requests are discarded. The FIFO is not rewound; its own reset governs its contents.
- Latency, with read sampled at edge E0 and the FIFO non-empty:
  - fifo_get high in cycle E0–E1
  - validout high in cycle E2–E3
  - so 2 edges from request to data
- Read while the FIFO is empty: request waits in `pending`. fifo_get asserts in the first cycle fifo_notempty = 1, and validout follows 2 edges later.
- Throughput: read held high with the FIFO non-empty gives validout high every cycle, one word per cycle.
- Read and fifo_get in the same cycle: pending unchanged.
- pending is never observed to exceed 2^PEND_W - 1 or go below 0.

## Test plan
- Reset: drive resetbar = 0 with read = 1 and fifo_notempty = 1 -> fifo_get = 0; all outputs 0 at the first edge after release.
- Single read: FIFO holds {0x0000100, 0xBEEF}; read pulse at E0 -> fifo_get in E0–E1; validout in E2–E3 with dout = 0xBEEF, raddr = 0x0000100.
- Burst: preload 8 entries with addr 0x3FFFFFC..0x0000003 (wrapping) and data 0..7; hold read 8 cycles -> 8 consecutive validouts, burst_done only on the 8th, addr_err = 0.
- Empty stall: 3 read pulses with FIFO empty -> pending = 3, no fifo_get. Then load 3 entries -> 3 pops back-to-back, pending returns to 0, 3 validouts.
- Overflow: 8 read pulses with FIFO empty and PEND_W = 3 -> pending = 7, overflow = 1 after the 8th pulse. Filling the FIFO then yields exactly 7 words.
- Address error: 2nd word of a burst at addr 0x0000105 after 0x0000100 -> addr_err = 1 and stays 1 through later correct bursts until reset.
